sample_capture: RTL and testbench
=================================

Name: sample_capture

Overview:
- Capture sink for the filter chain: records a stream of signed filter outputs (e.g. integrator dout) into an internal RAM, one sample per clock while enabled.
- Mirror of the sample-ROM source. The ROM reads stored samples out under start/over. This block writes samples in under the same start/over handshake, then exposes the buffer through a synchronous readback port.
- Sits at the end of the differentiator->integrator pipeline. Used both in benches and for on-chip result inspection.

Parameters:
- NBIT, 16, sample width in bits (two's complement).
- DEPTH, 1024, number of capture words.
- AW, 10, address width; must satisfy 2^AW >= DEPTH.
- SKIP, 2, number of leading samples discarded after start; covers upstream pipeline latency.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  capture enable; same signal that drives the sample source.
- din  input  NBIT  signed sample, valid every cycle while start=1.
- over  output  1  buffer full / capture complete; held until reset.
- busy  output  1  high in SKIP or CAPTURE.
- count  output  AW+1  number of samples stored so far.
- rd_en  input  1  readback request.
- rd_addr  input  AW  readback address.
- rd_data  output  NBIT  signed readback word.
- rd_valid  output  1  rd_data qualifier.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; over=0, busy=0, count=0, rd_data=0, rd_valid=0; internal skip counter=0.
  - RAM contents are not cleared.
  - rst has priority over every other input, including mid-capture. Capture aborts, count returns to 0.
- States:
  - IDLE: waits for start=1.
    - start=1 and SKIP>0 -> SKIP, with skip counter=1; the din of that first cycle is discarded.
    - start=1 and SKIP=0 -> CAPTURE, and that same cycle's din is written to address 0.
  - SKIP: discards din while start=1. The skip counter increments each start=1 cycle. When skip counter==SKIP, the current din is written to address 0 (count=1) and state -> CAPTURE.
  - CAPTURE: each cycle with start=1, writes din to RAM[count] and increments count. The write that makes count==DEPTH sets over=1 next cycle; state -> DONE.
  - DONE: no further writes; over=1, busy=0. Leaves only via rst.
  - start=0 in SKIP or CAPTURE pauses: no write, no count or skip increment, state unchanged. Capture resumes when start returns to 1.
  - start=1 in DONE is ignored.
- Write latency: the sample present at posedge N is readable from cycle N+1.
- count saturates at DEPTH; never wraps.
- busy = (state==SKIP || state==CAPTURE), registered.
- Readback:
  - rd_en=1 at posedge N -> rd_data=RAM[rd_addr] and rd_valid=1 after posedge N. Latency is 1 cycle.
  - rd_valid=0 on any cycle without rd_en; rd_data holds its last value.
  - rd_addr >= DEPTH -> rd_data=0, rd_valid=1.
  - Readback is allowed in any state. A simultaneous write and read to the same address returns the old word (read-before-write).
- No arithmetic on data; sign is preserved bit-exact.

Optional Feature:
- Macro: SAMPLE_CAPTURE_TRIG_EN.
- Defined:
  - Adds input trig_level (NBIT, signed) and a state ARMED between SKIP and CAPTURE.
  - After the skip phase, samples are discarded until din >= trig_level (signed compare) with start=1. That sample becomes address 0.
  - busy stays high in ARMED; start=0 pauses ARMED like other states.
  - Use: capture aligned to the first QRS peak.
- Undefined: no trig_level port, no ARMED state; behaviour exactly as above.

Test Plan:
- Reset/idle: hold rst 3 cycles, then start=0 for 10 cycles -> over=0, busy=0, count=0, rd_valid=0 throughout.
- Full capture: DEPTH=8, SKIP=2, din=k on start-cycle k (k=0..) -> samples 0,1 dropped; RAM[0..7]=2..9; over rises the cycle after din=9 is written; count=8; readback of addresses 0..7 returns 2..9 with rd_valid one cycle after each rd_en.
- Pause: deassert start for 3 cycles after 4 stored words -> count holds at 4, no writes; on resume the next din lands at address 4.
- Signed data/out-of-range read: din=-32768, 32767, -1 captured -> readback bit-exact 16'h8000, 16'h7FFF, 16'hFFFF; rd_addr=9 with DEPTH=8 -> rd_data=0, rd_valid=1.
- Mid-capture reset: rst=1 after 5 stored words -> next cycle state=IDLE, count=0, busy=0. A new start begins a fresh skip phase and the first kept sample overwrites address 0.
- Trigger (SAMPLE_CAPTURE_TRIG_EN): trig_level=100, din ramps by 25 from 0, SKIP=0 -> RAM[0]=100; samples 0..75 are not stored.

Source files
------------

// File: rtl/sample_capture.sv
// sample_capture: records a signed sample stream into RAM under start/over with synchronous readback; SAMPLE_CAPTURE_TRIG_EN adds a level trigger
module sample_capture #(
  parameter int NBIT = 16,
  parameter int DEPTH = 1024,
  parameter int AW = 10,
  parameter int SKIP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic signed [NBIT-1:0] din,
`ifdef SAMPLE_CAPTURE_TRIG_EN
  input  logic signed [NBIT-1:0] trig_level,
`endif
  output logic                   over,
  output logic                   busy,
  output logic [AW:0]            count,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic signed [NBIT-1:0] rd_data,
  output logic                   rd_valid
);
  localparam int DW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(SKIP + 2);
  typedef enum logic [2:0] {
    S_IDLE, S_SKIP,
`ifdef SAMPLE_CAPTURE_TRIG_EN
    S_ARMED,
`endif
    S_CAPTURE, S_DONE
  } state_t;
  state_t state, state_n;
  logic [SW-1:0] skip_cnt, skip_n;
  logic hit, armed, first, wr;
  logic signed [NBIT-1:0] mem [DEPTH];
`ifdef SAMPLE_CAPTURE_TRIG_EN
  assign hit = din >= trig_level;
  assign armed = state == S_ARMED;
`else
  assign hit = 1'b1;
  assign armed = 1'b0;
`endif
  assign first = start && ((state == S_IDLE && SKIP == 0) || (state == S_SKIP && skip_cnt == SW'(SKIP)) || armed);
  assign wr = (first && hit) || (state == S_CAPTURE && start);
  // next state: skip counting, trigger arming, and the write that fills the buffer
  always_comb begin
    state_n = state;
    skip_n = skip_cnt;
    case (state)
      S_IDLE: if (start && SKIP != 0) begin
        state_n = S_SKIP;
        skip_n = SW'(1);
      end
      S_SKIP: if (start && skip_cnt != SW'(SKIP)) skip_n = skip_cnt + 1'b1;
      default: ;
    endcase
`ifdef SAMPLE_CAPTURE_TRIG_EN
    if (first && !hit) state_n = S_ARMED;
`endif
    if (wr) state_n = count == (AW+1)'(DEPTH - 1) ? S_DONE : S_CAPTURE;
  end
  // state register, capture count and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      skip_cnt <= '0;
      count <= '0;
      over <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      skip_cnt <= skip_n;
      count <= count + (AW+1)'(wr);
      over <= state_n == S_DONE;
      busy <= state_n != S_IDLE && state_n != S_DONE;
    end
  end
  // capture RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr && !rst) mem[count[DW-1:0]] <= din;
  end
  // readback port: one-cycle latency, old word on read/write collision, zero beyond DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= {1'b0, rd_addr} < (AW+1)'(DEPTH) ? mem[rd_addr[DW-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: table vectors, directed corner sequences and random traffic against a sample-index model
module tb_sample_capture;
  localparam int DEPTH = 8;
  localparam int SKIP = 2;
  logic clk = 0, rst = 0, start = 0, rd_en = 0;
  logic [15:0] din = 0, rd_data, trig = 16'h8000;
  logic [3:0] rd_addr = 0;
  logic [4:0] count;
  logic over, busy, rd_valid;
  int checks = 0, failures = 0;
  int m_cnt = 0, m_seen = 0;
  bit m_hit = 0, m_started = 0, m_rdv = 0, m_rdk = 1;
  logic [15:0] m_rdd = 0;
  logic [15:0] m_mem [DEPTH];
  bit m_wr [DEPTH];
  typedef struct { bit s; logic [15:0] d; int cnt; bit busy; bit over; } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  sample_capture #(.NBIT(16), .DEPTH(DEPTH), .AW(4), .SKIP(SKIP)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din),
`ifdef SAMPLE_CAPTURE_TRIG_EN
    .trig_level(trig),
`endif
    .over(over), .busy(busy), .count(count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [15:0] d, input bit re, input logic [3:0] ra);
    rst = r; start = s; din = d; rd_en = re; rd_addr = ra;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_seen = 0; m_hit = 0; m_started = 0; m_rdv = 0; m_rdd = 0; m_rdk = 1;
    end else begin
      m_rdv = re;
      if (re) begin
        if (ra >= DEPTH) begin m_rdd = 0; m_rdk = 1; end
        else begin m_rdd = m_mem[ra]; m_rdk = m_wr[ra]; end
      end
      if (s && m_cnt < DEPTH) begin
        m_started = 1;
        if (m_seen >= SKIP && (m_hit || $signed(d) >= $signed(trig))) begin
          m_hit = 1; m_mem[m_cnt] = d; m_wr[m_cnt] = 1; m_cnt++;
        end
        m_seen++;
      end
    end
    #1;
    check("count", count, m_cnt);
    check("over", over, m_cnt == DEPTH);
    check("busy", busy, m_started && m_cnt < DEPTH);
    check("rd_valid", rd_valid, m_rdv);
    if (m_rdk) check("rd_data", rd_data, m_rdd);
  endtask

  initial begin
    tbl = '{'{1, 0, 0, 1, 0}, '{1, 1, 0, 1, 0}, '{1, 2, 1, 1, 0}, '{1, 3, 2, 1, 0},
            '{1, 4, 3, 1, 0}, '{1, 5, 4, 1, 0}, '{1, 6, 5, 1, 0}, '{1, 7, 6, 1, 0},
            '{1, 8, 7, 1, 0}, '{1, 9, 8, 0, 1}, '{1, 10, 8, 0, 1}, '{0, 11, 8, 0, 1}};
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].s, tbl[i].d, 0, 0);
      check("tbl_count", count, tbl[i].cnt);
      check("tbl_busy", busy, tbl[i].busy);
      check("tbl_over", over, tbl[i].over);
    end
    for (int a = 0; a < 8; a++) begin
      step(0, 0, 0, 1, 4'(a));
      check("readback", rd_data, a + 2);
    end
    step(0, 0, 0, 1, 9);
    check("oor_data", rd_data, 0);
    check("oor_valid", rd_valid, 1);
    step(0, 0, 0, 0, 0);
    check("idle_valid", rd_valid, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 16'(100 + i), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'hdead, 0, 0);
      check("pause_count", count, 4);
    end
    step(0, 1, 77, 0, 0);
    step(0, 1, 16'h8000, 0, 0);
    step(0, 1, 16'h7fff, 0, 0);
    step(0, 1, 16'hffff, 0, 0);
    check("signed_over", over, 1);
    step(0, 0, 0, 1, 4);
    check("resume_addr4", rd_data, 77);
    step(0, 0, 0, 1, 5);
    check("neg_full", rd_data, 16'h8000);
    step(0, 0, 0, 1, 6);
    check("pos_full", rd_data, 16'h7fff);
    step(0, 0, 0, 1, 7);
    check("minus_one", rd_data, 16'hffff);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 16'(200 + i), 0, 0);
    check("mid_count", count, 5);
    step(1, 1, 16'h1234, 0, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_busy", busy, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    step(0, 1, 555, 0, 0);
    step(0, 0, 0, 1, 0);
    check("fresh_addr0", rd_data, 555);
    for (int i = 0; i < 600; i++)
      step($urandom_range(59) == 0, $urandom_range(3) != 0, 16'($urandom), 1'($urandom), 4'($urandom_range(11)));
`ifdef SAMPLE_CAPTURE_TRIG_EN
    trig_test();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

`ifdef SAMPLE_CAPTURE_TRIG_EN
  logic t_rst = 1, t_start = 0, t_rd_en = 0, t_over, t_busy, t_rd_valid;
  logic [15:0] t_din = 0, t_rd_data, t_trig = 100;
  logic [3:0] t_rd_addr = 0;
  logic [4:0] t_count;

  sample_capture #(.NBIT(16), .DEPTH(DEPTH), .AW(4), .SKIP(0)) dut_t (
    .clk(clk), .rst(t_rst), .start(t_start), .din(t_din), .trig_level(t_trig),
    .over(t_over), .busy(t_busy), .count(t_count),
    .rd_en(t_rd_en), .rd_addr(t_rd_addr), .rd_data(t_rd_data), .rd_valid(t_rd_valid)
  );

  task automatic trig_test();
    t_rst = 1;
    @(posedge clk); #1;
    t_rst = 0; t_start = 1;
    for (int k = 0; k < 8; k++) begin
      t_din = 16'(25 * k);
      @(posedge clk); #1;
      check("trig_busy", t_busy, 1);
    end
    t_start = 0;
    check("trig_count", t_count, 4);
    t_rd_en = 1; t_rd_addr = 0;
    @(posedge clk); #1;
    check("trig_ram0", t_rd_data, 100);
    t_rd_addr = 3;
    @(posedge clk); #1;
    check("trig_ram3", t_rd_data, 175);
    t_rd_en = 0;
  endtask
`endif
endmodule
